// File: rtl/cheri_dm_abstract_cmd.sv
// CHERI debug module abstract command engine: decodes the abstract command
// register, stages the command word into debug memory, runs the hart
// transfer/program-buffer handshake and keeps the sticky cmderr code.
module cheri_dm_abstract_cmd #(
   parameter int unsigned DATA_WIDTH  = 33,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  dmactive_i,
   input  logic                  cmd_we_i,
   input  logic [31:0]           cmd_i,
   input  logic                  data_we_i,
   input  logic [1:0]            data_idx_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   input  logic [2:0]            cmderr_clr_i,
   output logic                  ac_en_o,
   output logic                  ac_write_o,
   output logic [3:0]            ac_addr_o,
   output logic [DATA_WIDTH-1:0] ac_wdata_o,
   input  logic [DATA_WIDTH-1:0] ac_rdata_i,
   output logic                  debug_transfer_reg_o,
   output logic                  debug_transfer_csr_o,
   output logic                  debug_transfer_scr_o,
   output logic                  debug_transfer_pgmb_o,
   input  logic                  debug_transfer_ack_i,
   input  logic                  halted_i,
   input  logic                  exception_i,
   output logic                  busy_o,
   output logic [2:0]            cmderr_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [2:0] ERR_BUSY   = 3'd1;
   localparam logic [2:0] ERR_NOTSUP = 3'd2;
   localparam logic [2:0] ERR_EXC    = 3'd3;
   localparam logic [2:0] ERR_HALT   = 3'd4;

   localparam logic [1:0] CLS_CSR = 2'd0;
   localparam logic [1:0] CLS_REG = 2'd1;
   localparam logic [1:0] CLS_SCR = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_XFER, S_XWAIT, S_PEXEC, S_PWAIT
   } state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic [2:0]       cmderr_q, cmderr_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]      cmd_q, cmd_d;
   logic [1:0]       cls_q, cls_d;
   logic             pexec_q, pexec_d;

   // Command field decode
   logic [7:0]  cmdtype;
   logic [2:0]  aarsize;
   logic        postexec, transfer;
   logic [15:0] regno;
   logic        is_csr, is_reg, is_scr, cmd_bad;
   logic [1:0]  cls_dec;
   logic        in_wait, timeout;

   assign cmdtype  = cmd_i[31:24];
   assign aarsize  = cmd_i[22:20];
   assign postexec = cmd_i[18];
   assign transfer = cmd_i[17];
   assign regno    = cmd_i[15:0];

   assign is_csr  = (regno[15:12] == 4'h0);
   assign is_reg  = (regno[15:5] == 11'h080);
   assign is_scr  = (regno[15:5] == 11'h100);
   assign cmd_bad = (cmdtype != 8'd0) || (aarsize != 3'd2) ||
                    (transfer && !(is_csr || is_reg || is_scr));
   assign cls_dec = is_reg ? CLS_REG : (is_scr ? CLS_SCR : CLS_CSR);

   assign in_wait = (state_q == S_XFER) || (state_q == S_XWAIT) ||
                    (state_q == S_PEXEC) || (state_q == S_PWAIT);
   assign timeout = in_wait && (wait_cnt_q == TIMEOUT_LAST);

   assign busy_o       = busy_q;
   assign cmderr_o     = cmderr_q;
   assign data_rdata_o = ac_rdata_i;

   // State and bookkeeping registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         cmderr_q   <= 3'd0;
         wait_cnt_q <= '0;
         cmd_q      <= 32'd0;
         cls_q      <= CLS_CSR;
         pexec_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         cmderr_q   <= cmderr_d;
         wait_cnt_q <= wait_cnt_d;
         cmd_q      <= cmd_d;
         cls_q      <= cls_d;
         pexec_q    <= pexec_d;
      end
   end

   // Next-state, error and wait-counter logic
   always_comb begin
      logic       err_set;
      logic [2:0] err_code;
      state_d  = state_q;
      cmd_d    = cmd_q;
      cls_d    = cls_q;
      pexec_d  = pexec_q;
      err_set  = 1'b0;
      err_code = 3'd0;

      if (cmd_we_i && (cmderr_q == 3'd0)) begin
         if (busy_q) begin
            err_set  = 1'b1;
            err_code = ERR_BUSY;
         end else if (cmd_bad) begin
            err_set  = 1'b1;
            err_code = ERR_NOTSUP;
         end else if (!halted_i) begin
            err_set  = 1'b1;
            err_code = ERR_HALT;
         end else begin
            cmd_d   = cmd_i;
            cls_d   = cls_dec;
            pexec_d = postexec;
            if (transfer)      state_d = S_ISSUE;
            else if (postexec) state_d = S_PEXEC;
         end
      end

      if (data_we_i && busy_q) begin
         err_set  = 1'b1;
         err_code = ERR_BUSY;
      end

      // Progress beats timeout when both land in the same cycle
      case (state_q)
         S_ISSUE: state_d = S_XFER;
         S_XFER: begin
            if (debug_transfer_ack_i) state_d = S_XWAIT;
            else if (timeout) begin
               err_set  = 1'b1;
               err_code = ERR_EXC;
               state_d  = S_IDLE;
            end
         end
         S_XWAIT: begin
            if (halted_i) state_d = pexec_q ? S_PEXEC : S_IDLE;
            else if (timeout) begin
               err_set  = 1'b1;
               err_code = ERR_EXC;
               state_d  = S_IDLE;
            end
         end
         S_PEXEC: begin
            if (debug_transfer_ack_i) state_d = S_PWAIT;
            else if (timeout) begin
               err_set  = 1'b1;
               err_code = ERR_EXC;
               state_d  = S_IDLE;
            end
         end
         S_PWAIT: begin
            if (halted_i) state_d = S_IDLE;
            else if (timeout) begin
               err_set  = 1'b1;
               err_code = ERR_EXC;
               state_d  = S_IDLE;
            end
         end
         default: ;
      endcase

      if (busy_q && exception_i) begin
         err_set  = 1'b1;
         err_code = ERR_EXC;
         state_d  = S_IDLE;
      end

      // Clear first so a same-cycle error replaces a cleared code
      cmderr_d = cmderr_q & ~cmderr_clr_i;
      if (err_set && (cmderr_d == 3'd0)) cmderr_d = err_code;

      if (state_d != state_q) wait_cnt_d = '0;
      else if (in_wait)       wait_cnt_d = wait_cnt_q + CNT_W'(1);
      else                    wait_cnt_d = wait_cnt_q;

      busy_d = (state_d != S_IDLE);

      if (!dmactive_i) begin
         state_d    = S_IDLE;
         cmderr_d   = 3'd0;
         wait_cnt_d = '0;
         busy_d     = 1'b0;
      end
   end

   // Memory port and hart request flags
   always_comb begin
      ac_en_o               = 1'b0;
      ac_write_o            = 1'b0;
      ac_addr_o             = {2'b00, data_idx_i};
      ac_wdata_o            = '0;
      debug_transfer_reg_o  = 1'b0;
      debug_transfer_csr_o  = 1'b0;
      debug_transfer_scr_o  = 1'b0;
      debug_transfer_pgmb_o = 1'b0;
      if (dmactive_i) begin
         case (state_q)
            S_IDLE: begin
               if (data_we_i) begin
                  ac_en_o    = 1'b1;
                  ac_write_o = 1'b1;
                  ac_wdata_o = data_wdata_i;
               end
            end
            S_ISSUE: begin
               ac_en_o    = 1'b1;
               ac_write_o = 1'b1;
               ac_addr_o  = 4'd2;
               ac_wdata_o = DATA_WIDTH'(cmd_q);
            end
            S_XFER: begin
               case (cls_q)
                  CLS_REG: debug_transfer_reg_o = 1'b1;
                  CLS_SCR: debug_transfer_scr_o = 1'b1;
                  default: debug_transfer_csr_o = 1'b1;
               endcase
            end
            S_PEXEC: debug_transfer_pgmb_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
